mux_sel_rr_arbiter: RTL and testbench

//  Round-robin arbiter that drives the 2-bit select of the 4:1 x 2-bit mux stage.

---
 rtl/mux_sel_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter that drives the 2-bit select of a 4:1 mux with a minimum dwell per grant.
// Optional feature macro: MUX_SEL_LOCK_EN adds a lock input that suppresses timeslice preemption.
module mux_sel_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef MUX_SEL_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       last, last_n;
    logic [1:0]       sel_n;
    logic [3:0]       grant_n;
    logic             valid_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             hold_lock;
    logic             other_req;
    logic             release_v;
    logic [2:0]       idle_pick;
    logic [2:0]       rel_pick;

    // First set bit scanning upward from start with wrap; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef MUX_SEL_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    assign other_req = |(req & ~(4'b0001 << sel));
    assign idle_pick = rr_pick(req, last + 2'd1);
    assign rel_pick  = rr_pick(req & ~(4'b0001 << sel), sel + 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'b00;
            grant <= 4'b0000;
            valid <= 1'b0;
            cnt   <= '0;
            last  <= 2'd3;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            grant <= grant_n;
            valid <= valid_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    // Next-state: idle pick, voluntary release, timeslice preemption, same-edge hand-off.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        grant_n   = grant;
        valid_n   = valid;
        cnt_n     = cnt;
        last_n    = last;
        release_v = 1'b0;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                grant_n = 4'b0000;
                cnt_n   = '0;
                if (idle_pick[2]) begin
                    state_n = GRANT;
                    sel_n   = idle_pick[1:0];
                    last_n  = idle_pick[1:0];
                    grant_n = 4'(4'b0001 << idle_pick[1:0]);
                    valid_n = 1'b1;
                end
            end
            GRANT: begin
                release_v = !req[sel] || ((cnt == CNT_MAX) && other_req && !hold_lock);
                if (release_v) begin
                    cnt_n = '0;
                    if (rel_pick[2]) begin
                        sel_n   = rel_pick[1:0];
                        last_n  = rel_pick[1:0];
                        grant_n = 4'(4'b0001 << rel_pick[1:0]);
                        valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                        valid_n = 1'b0;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Scoreboard bench for mux_sel_rr_arbiter: directed scenarios plus randomized traffic
// against a behavioural round-robin model; honours MUX_SEL_LOCK_EN when defined.
module tb_mux_sel_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural reference state
    bit   m_busy;
    int   m_sel;
    int   m_last;
    int   m_dwell;

    mux_sel_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef MUX_SEL_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .grant (grant),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Next requester strictly after 'from', wrapping around the four sources.
    function automatic int pick_after(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_sel   = 0;
        m_last  = 3;
        m_dwell = 0;
    endtask

    // Advance the model by one clock given the inputs sampled on that clock.
    task automatic model_edge(input logic [3:0] r, input logic l);
        logic [3:0] cand;
        bit         lk;
        bit         rel;
        int         w;
        exp_t       e;
`ifdef MUX_SEL_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
`endif
        if (!m_busy) begin
            if (r != 4'b0000) begin
                w       = pick_after(r, m_last);
                m_sel   = w;
                m_last  = w;
                m_busy  = 1'b1;
                m_dwell = 0;
            end
        end else begin
            cand    = r;
            cand[m_sel] = 1'b0;
            rel = !r[m_sel] || (m_dwell >= HOLD - 1 && cand != 4'b0000 && !lk);
            if (rel) begin
                if (cand != 4'b0000) begin
                    w       = pick_after(cand, m_sel);
                    m_sel   = w;
                    m_last  = w;
                    m_dwell = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_dwell++;
            end
        end
        e.sel   = 2'(m_sel);
        e.grant = m_busy ? 4'(1 << m_sel) : 4'b0000;
        e.valid = m_busy;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; returns shortly after the edge, outputs settled.
    task automatic step(input logic [3:0] r, input logic l);
        @(negedge clk);
        req  = r;
        lock = l;
        model_edge(r, l);
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        req  = 4'b0000;
        lock = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every clocked output against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_sel", 32'(sel), 32'(e.sel));
            chk("sb_grant", 32'(grant), 32'(e.grant));
            chk("sb_valid", 32'(valid), 32'(e.valid));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic       l;
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 1'b0;
        model_reset();
        #12;
        chk("por_sel", 32'(sel), 32'd0);
        chk("por_grant", 32'(grant), 32'd0);
        chk("por_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during an active grant of source 2, then first grant goes to source 3
        step(4'b0100, 1'b0);
        chk("t1_pre_grant", 32'(grant), 32'h4);
        do_reset();
        step(4'b1000, 1'b0);
        chk("t1_sel", 32'(sel), 32'd3);
        chk("t1_grant", 32'(grant), 32'h8);

        // Single requester holds indefinitely, then releases to idle
        do_reset();
        step(4'b0100, 1'b0);
        chk("t2_sel", 32'(sel), 32'd2);
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
        chk("t2_hold_grant", 32'(grant), 32'h4);
        step(4'b0000, 1'b0);
        chk("t2_idle_valid", 32'(valid), 32'd0);
        chk("t2_idle_grant", 32'(grant), 32'd0);
        chk("t2_idle_sel", 32'(sel), 32'd2);

        // Full load rotates every HOLD clocks without bubbles
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(4'b1111, 1'b0);
            chk("t3_grant", 32'(grant), 32'(1 << ((i / HOLD) % 4)));
            chk("t3_valid", 32'(valid), 32'd1);
        end

        // Preemption after the full timeslice
        do_reset();
        step(4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1001, 1'b0);
            chk("t4_hold", 32'(grant), 32'h1);
        end
        step(4'b1001, 1'b0);
        chk("t4_grant", 32'(grant), 32'h8);
        chk("t4_sel", 32'(sel), 32'd3);

        // Same-edge hand-off when the holder drops as others rise
        do_reset();
        step(4'b0010, 1'b0);
        chk("t5_first", 32'(grant), 32'h2);
        step(4'b0101, 1'b0);
        chk("t5_grant", 32'(grant), 32'h4);
        chk("t5_sel", 32'(sel), 32'd2);
        chk("t5_valid", 32'(valid), 32'd1);

`ifdef MUX_SEL_LOCK_EN
        // Lock suppresses preemption; release of lock preempts on the next edge
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b1);
            chk("t6_locked", 32'(grant), 32'h1);
        end
        step(4'b1111, 1'b0);
        chk("t6_unlock", 32'(grant), 32'h2);
`endif

        // Randomized traffic with sticky requests and occasional async resets
        do_reset();
        r = 4'b0000;
        l = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) r = r ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) l = ~l;
            step(r, l);
            if (valid) chk("rnd_onehot", 32'(grant), 32'(1 << sel));
            if (i % 150 == 149) do_reset();
        end

        @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
